seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_pkg.sv | 43 ++++
 rtl/seven_seg_scan_bcd_to_seg.sv | 27 ++
 rtl/seven_seg_scan.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scan.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the three-digit seven-segment scanner.
package seven_seg_pkg;

   // Counter width covers the full legal SCAN_DIV range (up to 65535).
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned EN_W    = 3;

   // Scan order: hundreds, tens, ones, then back to hundreds.
   typedef enum logic [1:0] {
      S_HUND = 2'd0,
      S_TENS = 2'd1,
      S_ONES = 2'd2
   } state_e;

   // Three BCD digits travelling together from load to display.
   typedef struct packed {
      logic [DIGIT_W-1:0] hund;
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] ones;
   } bcd3_t;

   // Bit positions of each digit in digit_en_n.
   localparam logic [1:0] DIG_HUND = 2'd2;
   localparam logic [1:0] DIG_TENS = 2'd1;
   localparam logic [1:0] DIG_ONES = 2'd0;

   // Active-low segment patterns, bit order g..a.
   localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_c_o
);

   // Pure lookup, no state.
   always_comb begin
      seg_c_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_c_o = SEG_0;
         4'd1:    seg_c_o = SEG_1;
         4'd2:    seg_c_o = SEG_2;
         4'd3:    seg_c_o = SEG_3;
         4'd4:    seg_c_o = SEG_4;
         4'd5:    seg_c_o = SEG_5;
         4'd6:    seg_c_o = SEG_6;
         4'd7:    seg_c_o = SEG_7;
         4'd8:    seg_c_o = SEG_8;
         4'd9:    seg_c_o = SEG_9;
         default: seg_c_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Three-digit multiplexed seven-segment scanner with frame-synchronous update.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 12000,
   parameter int unsigned BLANK_CYC = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [7:0] seg_n,
   output logic [2:0] digit_en_n,
   output logic       frame_done
);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   bcd3_t               disp_q, disp_d;
   bcd3_t               pend_q, pend_d;
   logic                pend_vld_q, pend_vld_d;
   logic [7:0]          seg_n_q;
   logic [EN_W-1:0]     en_n_q;
   logic                frame_done_q;

   logic                slot_end_c;
   logic                frame_end_c;
   bcd3_t               incoming_c;
   logic [DIGIT_W-1:0]  cur_digit_c;
   logic [SEG_W-1:0]    cur_seg_c;
   logic [EN_W-1:0]     en_n_c;
   logic                lzb_hund_c;
   logic                lzb_tens_c;

   assign slot_end_c  = (cnt_q == SLOT_LAST);
   assign frame_end_c = slot_end_c && (state_q == S_ONES);
   assign incoming_c  = {hundreds, tens, ones};

   // Select the displayed digit for the slot currently being scanned.
   always_comb begin
      cur_digit_c = '0;
      case (state_q)
         S_HUND:  cur_digit_c = disp_q.hund;
         S_TENS:  cur_digit_c = disp_q.tens;
         S_ONES:  cur_digit_c = disp_q.ones;
         default: cur_digit_c = '0;
      endcase
   end

   bcd_to_seg u_dec (
      .bcd_i   (cur_digit_c),
      .seg_c_o (cur_seg_c)
   );

   // Leading-zero suppression flags; the ones digit is never suppressed.
   always_comb begin
`ifdef SEVEN_SEG_LZB_EN
      lzb_hund_c = (disp_q.hund == 4'd0);
      lzb_tens_c = (disp_q.hund == 4'd0) && (disp_q.tens == 4'd0);
`else
      lzb_hund_c = 1'b0;
      lzb_tens_c = 1'b0;
`endif
   end

   // Digit enables: all off during the anti-ghost window, else the active slot only.
   always_comb begin
      en_n_c = '1;
      if (cnt_q >= BLANK_END) begin
         case (state_q)
            S_HUND:  en_n_c[DIG_HUND] = lzb_hund_c;
            S_TENS:  en_n_c[DIG_TENS] = lzb_tens_c;
            S_ONES:  en_n_c[DIG_ONES] = 1'b0;
            default: en_n_c = '1;
         endcase
      end
   end

   // Loads park in the pending register and only reach the display at a frame boundary.
   always_comb begin
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (frame_end_c) begin
         if (load) begin
            disp_d = incoming_c;
         end else if (pend_vld_q) begin
            disp_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (load) begin
         pend_d     = incoming_c;
         pend_vld_d = 1'b1;
      end
   end

   // Scan FSM, slot counter and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_HUND;
         cnt_q        <= '0;
         seg_n_q      <= {1'b1, SEG_OFF};
         en_n_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         if (slot_end_c) begin
            cnt_q <= '0;
            case (state_q)
               S_HUND:  state_q <= S_TENS;
               S_TENS:  state_q <= S_ONES;
               default: state_q <= S_HUND;
            endcase
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         seg_n_q      <= {1'b1, cur_seg_c};
         en_n_q       <= en_n_c;
         frame_done_q <= frame_end_c;
      end
   end

   // Display and pending digit storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign digit_en_n = en_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (SCAN_DIV=4, BLANK_CYC=1).
// Honours SEVEN_SEG_LZB_EN when the design is built with it.
module tb_seven_seg_scan;

   localparam int SD    = 4;
   localparam int BC    = 1;
   localparam int FRAME = 3 * SD;

`ifdef SEVEN_SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] hundreds, tens, ones;
   logic [7:0] seg_n;
   logic [2:0] digit_en_n;
   logic       frame_done;

   seven_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .hundreds   (hundreds),
      .tens       (tens),
      .ones       (ones),
      .seg_n      (seg_n),
      .digit_en_n (digit_en_n),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: k = cycles since reset release, digits indexed 0=hund,1=tens,2=ones.
   logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
   int         k = 0;
   logic [3:0] m_disp [3];
   logic [3:0] m_pend [3];
   bit         m_pv = 1'b0;
   logic [7:0] exp_seg;
   logic [2:0] exp_en;
   logic       exp_fd;

   // One clock: advance the model with the inputs seen at the edge, then settle.
   task automatic tick();
      int slot, pos;
      @(posedge clk);
      if (rst) begin
         k = 0;
         for (int d = 0; d < 3; d++) begin m_disp[d] = 4'd0; m_pend[d] = 4'd0; end
         m_pv    = 1'b0;
         exp_seg = 8'hFF;
         exp_en  = 3'b111;
         exp_fd  = 1'b0;
      end else begin
         slot    = (k / SD) % 3;
         pos     = k % SD;
         exp_seg = {1'b1, seg_tab[m_disp[slot]]};
         exp_en  = 3'b111;
         if (pos >= BC) exp_en[2 - slot] = 1'b0;
         if (LZB && slot == 0 && m_disp[0] == 4'd0) exp_en = 3'b111;
         if (LZB && slot == 1 && m_disp[0] == 4'd0 && m_disp[1] == 4'd0) exp_en = 3'b111;
         exp_fd = (slot == 2) && (pos == SD - 1);
         if (exp_fd) begin
            if (load) begin
               m_disp[0] = hundreds; m_disp[1] = tens; m_disp[2] = ones;
            end else if (m_pv) begin
               m_disp = m_pend;
            end
            m_pv = 1'b0;
         end else if (load) begin
            m_pend[0] = hundreds; m_pend[1] = tens; m_pend[2] = ones;
            m_pv = 1'b1;
         end
         k++;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; {hundreds, tens, ones} = 12'h000;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin load = 1'b1; {hundreds, tens, ones} = 12'h888; end
         tick();
         load = 1'b0;
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {8'hFF, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL reset_out cyc=%0d got seg_n=%h en=%b fd=%b want seg_n=ff en=111 fd=0",
                     i, seg_n, digit_en_n, frame_done);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd} || digit_en_n !== 3'b111) begin
         failures++;
         $display("FAIL release_blank got seg_n=%h en=%b fd=%b want seg_n=%h en=111 fd=%b",
                  seg_n, digit_en_n, frame_done, exp_seg, exp_fd);
      end
   endtask

   task automatic test_load_basic();
      int hits [3];
      int win;
      hits = '{0, 0, 0};
      win  = -1;
      for (int i = 0; i < 40; i++) begin
         load = (i == 1);
         {hundreds, tens, ones} = 12'h255;
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL load_basic k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
         if (win >= 0 && win < FRAME) begin
            if (digit_en_n == 3'b011 && seg_n[6:0] == 7'b0100100) hits[0]++;
            if (digit_en_n == 3'b101 && seg_n[6:0] == 7'b0010010) hits[1]++;
            if (digit_en_n == 3'b110 && seg_n[6:0] == 7'b0010010) hits[2]++;
            win++;
         end
         if (win < 0 && i >= 1 && frame_done === 1'b1) win = 0;
      end
      load = 1'b0;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (hits[d] != SD - BC) begin
            failures++;
            $display("FAIL load_basic_slot%0d enabled_cycles got=%0d want=%0d", d, hits[d], SD - BC);
         end
      end
   endtask

   task automatic test_last_wins();
      int good, bad, win, j;
      good = 0; bad = 0; win = -1; j = -1;
      for (int i = 0; i < 60; i++) begin
         load = (j == 1) || (j == 4);
         {hundreds, tens, ones} = (j == 1) ? 12'h123 : 12'h456;
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL last_wins k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
         if (win >= 0 && win < FRAME) begin
            if (digit_en_n == 3'b011 && seg_n[6:0] == 7'b0011001) good++;
            if (digit_en_n == 3'b101 && seg_n[6:0] == 7'b0010010) good++;
            if (digit_en_n == 3'b110 && seg_n[6:0] == 7'b0000010) good++;
            if (digit_en_n == 3'b011 && seg_n[6:0] == 7'b1111001) bad++;
            if (digit_en_n == 3'b101 && seg_n[6:0] == 7'b0100100) bad++;
            if (digit_en_n == 3'b110 && seg_n[6:0] == 7'b0110000) bad++;
            win++;
         end
         if (j >= 0) j++;
         if (j < 0 && frame_done === 1'b1) j = 0;
         if (j == FRAME) win = 0;
      end
      load = 1'b0;
      checks++;
      if (good != 3 * (SD - BC) || bad != 0) begin
         failures++;
         $display("FAIL last_wins_frame good=%0d bad=%0d want good=%0d bad=0", good, bad, 3 * (SD - BC));
      end
   endtask

   task automatic test_commit_cycle();
      int hund_on, tens_on, ones7, win;
      bit fired;
      hund_on = 0; tens_on = 0; ones7 = 0; win = -1; fired = 1'b0;
      for (int i = 0; i < 40; i++) begin
         load = !fired && ((k % FRAME) == FRAME - 1);
         {hundreds, tens, ones} = 12'h007;
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL commit_cycle k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
         if (win >= 0 && win < FRAME) begin
            if (digit_en_n == 3'b011 && seg_n[6:0] == 7'b1000000) hund_on++;
            if (digit_en_n == 3'b101 && seg_n[6:0] == 7'b1000000) tens_on++;
            if (digit_en_n == 3'b110 && seg_n[6:0] == 7'b1111000) ones7++;
            win++;
         end
         if (load) begin fired = 1'b1; win = 0; end
      end
      load = 1'b0;
      checks++;
      if (hund_on != (LZB ? 0 : SD - BC) || tens_on != (LZB ? 0 : SD - BC) || ones7 != SD - BC) begin
         failures++;
         $display("FAIL commit_cycle_frame hund=%0d tens=%0d ones7=%0d want hund=%0d tens=%0d ones7=%0d",
                  hund_on, tens_on, ones7, LZB ? 0 : SD - BC, LZB ? 0 : SD - BC, SD - BC);
      end
   endtask

   task automatic test_dash();
      int dash, win;
      dash = 0; win = -1;
      for (int i = 0; i < 40; i++) begin
         load = (i == 1);
         hundreds = 4'hC;
         tens     = 4'($urandom_range(0, 9));
         ones     = 4'($urandom_range(0, 9));
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL dash k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
         if (win >= 0 && win < FRAME) begin
            if (digit_en_n == 3'b011 && seg_n == 8'b1011_1111) dash++;
            win++;
         end
         if (win < 0 && i >= 1 && frame_done === 1'b1) win = 0;
      end
      load = 1'b0;
      checks++;
      if (dash != SD - BC) begin
         failures++;
         $display("FAIL dash_hund_slot got=%0d want=%0d", dash, SD - BC);
      end
   endtask

   task automatic test_mid_reset();
      int stage, post, hund0, nines;
      stage = 0; post = -1; hund0 = 0; nines = 0;
      for (int i = 0; i < 50; i++) begin
         rst = 1'b0; load = 1'b0;
         if (stage == 0 && (k % FRAME) == 1) begin
            load = 1'b1; {hundreds, tens, ones} = 12'h999; stage = 1;
         end else if (stage == 1 && (k % FRAME) == SD + 1) begin
            rst = 1'b1; load = 1'b1; {hundreds, tens, ones} = 12'h333; stage = 2;
         end
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL mid_reset k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
         if (rst) begin
            checks++;
            if ({seg_n, digit_en_n, frame_done} !== {8'hFF, 3'b111, 1'b0}) begin
               failures++;
               $display("FAIL mid_reset_out got seg_n=%h en=%b fd=%b want seg_n=ff en=111 fd=0",
                        seg_n, digit_en_n, frame_done);
            end
            post = 0;
         end else if (post >= 0 && post < FRAME) begin
            if (post == 0) begin
               checks++;
               if (digit_en_n !== 3'b111) begin
                  failures++;
                  $display("FAIL mid_reset_blank got en=%b want en=111", digit_en_n);
               end
            end
            if (digit_en_n == 3'b011 && seg_n[6:0] == 7'b1000000) hund0++;
            if (digit_en_n != 3'b111 && (seg_n[6:0] == 7'b0010000 || seg_n[6:0] == 7'b0110000)) nines++;
            post++;
         end
      end
      rst = 1'b0; load = 1'b0;
      checks++;
      if (hund0 != (LZB ? 0 : SD - BC) || nines != 0 || stage != 2) begin
         failures++;
         $display("FAIL mid_reset_frame hund0=%0d stale=%0d stage=%0d want hund0=%0d stale=0 stage=2",
                  hund0, nines, stage, LZB ? 0 : SD - BC);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 149) == 0);
         load = ($urandom_range(0, 7) == 0);
         hundreds = 4'($urandom_range(0, 15));
         tens     = 4'($urandom_range(0, 15));
         ones     = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) hundreds = 4'd0;
         if ($urandom_range(0, 2) == 0) tens = 4'd0;
         tick();
         checks++;
         if ({seg_n, digit_en_n, frame_done} !== {exp_seg, exp_en, exp_fd}) begin
            failures++;
            $display("FAIL random k=%0d got seg_n=%h en=%b fd=%b want seg_n=%h en=%b fd=%b",
                     k, seg_n, digit_en_n, frame_done, exp_seg, exp_en, exp_fd);
         end
      end
      rst = 1'b0; load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
      test_reset();
      test_load_basic();
      test_last_wins();
      test_commit_cycle();
      test_dash();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
